// File: rtl/active_deserialize.sv
// active_deserialize
// Packs a serial stream of {last, data} beats into one wide vector of NO lanes
// plus an active-lane count. It is the receiving end of the active-count
// serialization path.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   din_valid  input beat valid
//   din_ready  input beat ready (low only while a vector is held and not taken)
//   din_data   input beat {last, data[W_DATA-1:0]}
//   dout_valid output vector valid
//   dout_ready output vector ready
//   dout_data  output vector {active, lane[NO-1] .. lane[0]}, lane 0 in the LSBs;
//              lanes at or above active are driven as zero
//   overflow   one-cycle pulse when a vector closes at NO beats without last
module active_deserialize #(
  parameter int W_DATA   = 16,
  parameter int NO       = 4,
  parameter int W_ACTIVE = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         din_valid,
  output logic                         din_ready,
  input  logic [W_DATA:0]              din_data,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic [W_ACTIVE+NO*W_DATA-1:0] dout_data,
  output logic                         overflow
);

  localparam int W_CNT = $clog2(NO);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [W_CNT-1:0]     cnt_q, cnt_d;
  logic [W_ACTIVE-1:0]  active_q, active_d;
  logic                 overflow_q, overflow_d;

  // Two lane banks: fill_q collects the vector under construction, out_q is
  // what is presented. Beats that arrive while a vector is held only ever
  // touch fill_q, so the presented lanes cannot change under the consumer.
  logic [W_DATA-1:0]    fill_q [NO];
  logic [W_DATA-1:0]    fill_d [NO];
  logic [W_DATA-1:0]    out_q  [NO];
  logic [W_DATA-1:0]    out_d  [NO];

  logic                 hold;
  logic                 accept;
  logic                 close_vec;
  logic                 beat_last;
  logic [W_DATA-1:0]    beat_data;

  assign hold       = (state_q == HOLD);
  assign beat_last  = din_data[W_DATA];
  assign beat_data  = din_data[W_DATA-1:0];

  // Taking a vector frees the output this cycle, so a new beat may be
  // accepted in the same cycle and back-to-back vectors need no bubble.
  assign din_ready  = !hold || dout_ready;
  assign accept     = din_valid && din_ready;
  assign close_vec  = accept && (beat_last || (cnt_q == W_CNT'(NO - 1)));

  assign dout_valid = hold;
  assign overflow   = overflow_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    active_d   = active_q;
    overflow_d = 1'b0;
    fill_d     = fill_q;
    out_d      = out_q;

    if (accept) begin
      for (int i = 0; i < NO; i++) begin
        if (W_CNT'(i) == cnt_q) begin
          fill_d[i] = beat_data;
        end
      end
      cnt_d = close_vec ? '0 : cnt_q + W_CNT'(1);
    end

    if (close_vec) begin
      // The closing beat goes straight into the output bank since it is not
      // yet visible in fill_q.
      for (int i = 0; i < NO; i++) begin
        out_d[i] = (W_CNT'(i) == cnt_q) ? beat_data : fill_q[i];
      end
      active_d   = W_ACTIVE'(cnt_q) + W_ACTIVE'(1);
      overflow_d = !beat_last;
      state_d    = HOLD;
    end else if (hold && dout_ready) begin
      state_d = FILL;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FILL;
      cnt_q      <= '0;
      active_q   <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < NO; i++) begin
        fill_q[i] <= '0;
        out_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      active_q   <= active_d;
      overflow_q <= overflow_d;
      fill_q     <= fill_d;
      out_q      <= out_d;
    end
  end

  // Lanes beyond the active count may hold stale data from earlier vectors,
  // so they are masked to zero on the way out.
  always_comb begin
    dout_data = '0;
    for (int i = 0; i < NO; i++) begin
      dout_data[i*W_DATA +: W_DATA] = (W_ACTIVE'(i) < active_q) ? out_q[i] : '0;
    end
    dout_data[W_ACTIVE+NO*W_DATA-1 -: W_ACTIVE] = active_q;
  end

endmodule

// File: tb/tb_active_deserialize.sv
// Testbench for active_deserialize (NO=4, W_DATA=16, W_ACTIVE=3).
// Directed scenarios followed by a randomized run. A transaction-level model
// collects accepted beats into a list and emits an expected vector whenever
// the list reaches NO beats or a last beat arrives.
module tb_active_deserialize;

  localparam int W_DATA   = 16;
  localparam int NO       = 4;
  localparam int W_ACTIVE = 3;
  localparam int W_OUT    = W_ACTIVE + NO * W_DATA;

  logic              clk;
  logic              rst;
  logic              din_valid;
  logic              din_ready;
  logic [W_DATA:0]   din_data;
  logic              dout_valid;
  logic              dout_ready;
  logic [W_OUT-1:0]  dout_data;
  logic              overflow;

  typedef struct {
    logic [W_OUT-1:0] data;
    logic             ovf;
  } vec_t;

  vec_t              exp_q[$];
  logic [W_DATA-1:0] cur_q[$];
  logic              prev_valid;
  logic              prev_hs;
  int                checks;
  int                errors;
  logic [W_OUT-1:0]  held_snapshot;

  active_deserialize #(
    .W_DATA  (W_DATA),
    .NO      (NO),
    .W_ACTIVE(W_ACTIVE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .din_data  (din_data),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_data (dout_data),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W_OUT-1:0] obs, input logic [W_OUT-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W_OUT-1:0] make_vec(input logic [W_DATA-1:0] lanes[$]);
    logic [W_OUT-1:0] v;
    v = '0;
    for (int i = 0; i < lanes.size(); i++) begin
      v[i*W_DATA +: W_DATA] = lanes[i];
    end
    v[W_OUT-1 -: W_ACTIVE] = W_ACTIVE'(lanes.size());
    return v;
  endfunction

  function automatic logic [W_OUT-1:0] vec4(input int act, input logic [15:0] l3, input logic [15:0] l2,
                                            input logic [15:0] l1, input logic [15:0] l0);
    return {W_ACTIVE'(act), l3, l2, l1, l0};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    cur_q.delete();
    prev_valid = 1'b0;
    prev_hs    = 1'b0;
  endtask

  // Apply one cycle of inputs, check the settled outputs against the model,
  // then advance the model by what the coming clock edge will transfer.
  task automatic drive(input logic v, input logic last, input logic [W_DATA-1:0] d, input logic rdy);
    logic acc;
    logic hs;
    logic fresh;
    vec_t nv;
    din_valid  = v;
    din_data   = {last, d};
    dout_ready = rdy;
    #2;
    acc   = din_valid && din_ready;
    hs    = dout_valid && dout_ready;
    fresh = dout_valid && (!prev_valid || prev_hs);
    check("din_ready", W_OUT'(din_ready), W_OUT'(!dout_valid || dout_ready));
    if (dout_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_vector", W_OUT'(dout_valid), W_OUT'(0));
      end else begin
        check("vector_data", dout_data, exp_q[0].data);
        check("overflow", W_OUT'(overflow), W_OUT'(fresh ? exp_q[0].ovf : 1'b0));
      end
    end else begin
      check("overflow_idle", W_OUT'(overflow), W_OUT'(0));
    end
    if (hs && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
    if (acc) begin
      cur_q.push_back(d);
      if (last || cur_q.size() == NO) begin
        nv.data = make_vec(cur_q);
        nv.ovf  = !last;
        exp_q.push_back(nv);
        cur_q.delete();
      end
    end
    prev_valid = dout_valid;
    prev_hs    = hs;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b0;
    din_valid  = 1'b0;
    din_data   = '0;
    dout_ready = 1'b0;
    model_reset();

    // Reset state
    #12;
    check("reset_valid", W_OUT'(dout_valid), W_OUT'(0));
    check("reset_overflow", W_OUT'(overflow), W_OUT'(0));
    check("reset_din_ready", W_OUT'(din_ready), W_OUT'(1));
    check("reset_data", dout_data, W_OUT'(0));
    rst = 1'b1;
    tick();

    // Three-beat vector
    drive(1'b1, 1'b0, 16'h1111, 1'b1); tick();
    drive(1'b1, 1'b0, 16'h2222, 1'b1); tick();
    drive(1'b1, 1'b1, 16'h3333, 1'b1); tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b1);
    check("three_beat", dout_data, vec4(3, 16'h0000, 16'h3333, 16'h2222, 16'h1111));
    check("three_beat_valid", W_OUT'(dout_valid), W_OUT'(1));
    check("three_beat_ovf", W_OUT'(overflow), W_OUT'(0));
    tick();

    // Back-to-back single-beat vectors
    drive(1'b1, 1'b1, 16'hABCD, 1'b1); tick();
    drive(1'b1, 1'b1, 16'h0042, 1'b1);
    check("single_a", dout_data, vec4(1, 16'h0, 16'h0, 16'h0, 16'hABCD));
    tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b1);
    check("single_b", dout_data, vec4(1, 16'h0, 16'h0, 16'h0, 16'h0042));
    tick();

    // Full vector with last on the fourth beat
    drive(1'b1, 1'b0, 16'hAAAA, 1'b1); tick();
    drive(1'b1, 1'b0, 16'hBBBB, 1'b1); tick();
    drive(1'b1, 1'b0, 16'hCCCC, 1'b1); tick();
    drive(1'b1, 1'b1, 16'hDDDD, 1'b1); tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b1);
    check("full_last", dout_data, vec4(4, 16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA));
    check("full_last_ovf", W_OUT'(overflow), W_OUT'(0));
    tick();

    // Five beats, last only on the fifth: overflow split
    drive(1'b1, 1'b0, 16'h0001, 1'b1); tick();
    drive(1'b1, 1'b0, 16'h0002, 1'b1); tick();
    drive(1'b1, 1'b0, 16'h0003, 1'b1); tick();
    drive(1'b1, 1'b0, 16'h0004, 1'b1); tick();
    drive(1'b1, 1'b1, 16'h0005, 1'b1);
    check("ovf_vec", dout_data, vec4(4, 16'h0004, 16'h0003, 16'h0002, 16'h0001));
    check("ovf_pulse", W_OUT'(overflow), W_OUT'(1));
    tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b1);
    check("ovf_tail", dout_data, vec4(1, 16'h0, 16'h0, 16'h0, 16'h0005));
    check("ovf_pulse_end", W_OUT'(overflow), W_OUT'(0));
    tick();

    // Back-pressure: held vector stays stable and blocks input
    drive(1'b1, 1'b0, 16'h0A0A, 1'b1); tick();
    drive(1'b1, 1'b1, 16'h0B0B, 1'b1); tick();
    held_snapshot = vec4(2, 16'h0, 16'h0, 16'h0B0B, 16'h0A0A);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 16'hC0C0, 1'b0);
      check("hold_din_ready", W_OUT'(din_ready), W_OUT'(0));
      check("hold_data", dout_data, held_snapshot);
      tick();
    end
    drive(1'b1, 1'b1, 16'hC0C0, 1'b1);
    check("release_din_ready", W_OUT'(din_ready), W_OUT'(1));
    check("release_valid", W_OUT'(dout_valid), W_OUT'(1));
    tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b1);
    check("after_release", dout_data, vec4(1, 16'h0, 16'h0, 16'h0, 16'hC0C0));
    tick();

    // Asynchronous reset mid-frame
    drive(1'b1, 1'b0, 16'h0101, 1'b1); tick();
    drive(1'b1, 1'b0, 16'h0202, 1'b1); tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b1);
    #1 rst = 1'b0;
    #1;
    check("async_rst_valid", W_OUT'(dout_valid), W_OUT'(0));
    model_reset();
    #1 rst = 1'b1;
    tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b1);
    check("post_rst_valid", W_OUT'(dout_valid), W_OUT'(0));
    tick();
    drive(1'b1, 1'b1, 16'h7777, 1'b1); tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b1);
    check("post_rst_vec", dout_data, vec4(1, 16'h0, 16'h0, 16'h0, 16'h7777));
    tick();

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3),
            W_DATA'($urandom), ($urandom_range(0, 9) < 6));
      tick();
    end

    // Drain whatever vectors remain, bounded
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
      drive(1'b0, 1'b0, 16'h0000, 1'b1);
      tick();
    end
    check("drain_empty", W_OUT'(exp_q.size()), W_OUT'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
